// File: rtl/port_uart_tx.sv
// ============================================================================
// Module   : port_uart_tx
// Brief    : Captures CPU port_out writes into a FIFO and sends each word as
//            8N1 UART bytes (MSB byte first), reporting status on port_in.
// Revision : 1.0
// ============================================================================
`default_nettype none

module port_uart_tx #(
   parameter int WIDTH_REG      = 32,
   parameter int FIFO_DEPTH_LOG = 2,
   parameter int CLK_DIV        = 434
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH_REG-1:0] cpu_port_out,
   output logic [WIDTH_REG-1:0] cpu_port_in,
   output logic                 uart_txd,
   output logic                 busy
);
   localparam int c_DEPTH  = 1 << FIFO_DEPTH_LOG;
   localparam int c_NBYTES = WIDTH_REG / 8;
   localparam int c_CNT_W  = $clog2(CLK_DIV);
   localparam int c_BIDX_W = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
   localparam logic [FIFO_DEPTH_LOG:0] c_FULL      = c_DEPTH[FIFO_DEPTH_LOG:0];
   localparam logic [c_CNT_W-1:0]      c_CNT_LAST  = c_CNT_W'(CLK_DIV - 1);
   localparam logic [c_BIDX_W-1:0]     c_LAST_BYTE = c_BIDX_W'(c_NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t                    r_state, w_state_nxt;
   logic [c_CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic [2:0]                r_bit, w_bit_nxt;
   logic [c_BIDX_W-1:0]       r_byte, w_byte_nxt;
   logic [WIDTH_REG-1:0]      r_shift, w_shift_nxt;
   logic                      r_txd, w_txd_nxt;
   logic [WIDTH_REG-1:0]      r_prev;
   logic [WIDTH_REG-1:0]      r_mem [c_DEPTH];
   logic [FIFO_DEPTH_LOG-1:0] r_wptr, r_rptr;
   logic [FIFO_DEPTH_LOG:0]   r_count;
   logic                      r_ovf;
   logic                      r_busy;
   logic [WIDTH_REG-1:0]      r_port_in, w_status;

   logic       w_push, w_full, w_empty, w_pop, w_wr, w_busy, w_last;
   logic [7:0] w_byte_act;
   logic [2:0] w_bit_inc;

   assign w_push     = (cpu_port_out != r_prev);
   assign w_full     = (r_count == c_FULL);
   assign w_empty    = (r_count == '0);
   assign w_pop      = (r_state == S_IDLE) && !w_empty;
   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign w_wr       = w_push && (!w_full || w_pop);
   assign w_busy     = (r_state != S_IDLE) || !w_empty;
   assign w_last     = (r_cnt == c_CNT_LAST);
   assign w_byte_act = r_shift[WIDTH_REG-1 -: 8];
   assign w_bit_inc  = r_bit + 3'd1;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= cpu_port_out;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prev  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_prev <= cpu_port_out;
         if (w_wr)  r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
         if (w_push && !w_wr) r_ovf <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_bit_nxt   = r_bit;
      w_byte_nxt  = r_byte;
      w_shift_nxt = r_shift;
      w_txd_nxt   = r_txd;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_txd_nxt = 1'b1;
            if (!w_empty) begin
               w_state_nxt = S_START;
               w_shift_nxt = r_mem[r_rptr];
               w_byte_nxt  = '0;
               w_txd_nxt   = 1'b0;
            end
         end
         S_START: begin
            if (w_last) begin
               w_state_nxt = S_DATA;
               w_cnt_nxt   = '0;
               w_bit_nxt   = 3'd0;
               w_txd_nxt   = w_byte_act[0];
            end
         end
         S_DATA: begin
            if (w_last) begin
               w_cnt_nxt = '0;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
                  w_txd_nxt   = 1'b1;
               end else begin
                  w_bit_nxt = w_bit_inc;
                  w_txd_nxt = w_byte_act[w_bit_inc];
               end
            end
         end
         S_STOP: begin
            if (w_last) begin
               w_cnt_nxt = '0;
               if (r_byte != c_LAST_BYTE) begin
                  w_state_nxt = S_START;
                  w_byte_nxt  = r_byte + 1'b1;
                  w_shift_nxt = r_shift << 8;
                  w_txd_nxt   = 1'b0;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_txd_nxt   = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
         end
      endcase
   end

   always_comb begin
      w_status                        = '0;
      w_status[0]                     = w_busy;
      w_status[1]                     = w_full;
      w_status[2]                     = r_ovf;
      w_status[3 +: FIFO_DEPTH_LOG+1] = r_count;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_byte    <= '0;
         r_shift   <= '0;
         r_txd     <= 1'b1;
         r_busy    <= 1'b0;
         r_port_in <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit     <= w_bit_nxt;
         r_byte    <= w_byte_nxt;
         r_shift   <= w_shift_nxt;
         r_txd     <= w_txd_nxt;
         r_busy    <= w_busy;
         r_port_in <= w_status;
      end
   end

   assign uart_txd    = r_txd;
   assign busy        = r_busy;
   assign cpu_port_in = r_port_in;

endmodule

`default_nettype wire

// File: tb/tb_port_uart_tx.sv
// ============================================================================
// Module   : tb_port_uart_tx
// Brief    : Directed bench for port_uart_tx with a byte scoreboard fed on
//            writes and drained by a serial-line decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_port_uart_tx;
   localparam int CLK_DIV = 4;

   logic        clk;
   logic        reset;
   logic [31:0] cpu_port_out;
   logic [31:0] cpu_port_in;
   logic        uart_txd;
   logic        busy;

   int n_tests;
   int n_fail;
   int n_frames;
   int n_aborts;
   int frames_before;
   logic [7:0] q_exp [$];

   port_uart_tx #(
      .WIDTH_REG      (32),
      .FIFO_DEPTH_LOG (2),
      .CLK_DIV        (CLK_DIV)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_port_out (cpu_port_out),
      .cpu_port_in  (cpu_port_in),
      .uart_txd     (uart_txd),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_word(input logic [31:0] w);
      q_exp.push_back(w[31:24]);
      q_exp.push_back(w[23:16]);
      q_exp.push_back(w[15:8]);
      q_exp.push_back(w[7:0]);
   endtask

   task automatic wait_idle(input int max_cyc, input string tag);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < max_cyc) begin
         step(1);
         k++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   // Serial decoder: every bit must hold for CLK_DIV cycles; bytes go to the scoreboard.
   initial begin : mon
      logic [9:0] bits;
      logic       stable;
      logic       abort;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && uart_txd === 1'b0) begin
            bits   = '0;
            stable = 1'b1;
            abort  = 1'b0;
            for (int s = 1; s < 10*CLK_DIV; s++) begin
               @(negedge clk);
               if (reset !== 1'b1) begin
                  abort = 1'b1;
                  break;
               end
               if (s % CLK_DIV == 0) bits[s/CLK_DIV] = uart_txd;
               else if (uart_txd !== bits[s/CLK_DIV]) stable = 1'b0;
            end
            if (abort) begin
               n_aborts++;
            end else begin
               n_frames++;
               chk("bit_hold", {31'd0, stable}, 32'd1);
               chk("stop_bit", {31'd0, bits[9]}, 32'd1);
               if (q_exp.size() == 0) chk("unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
               else                   chk("frame_byte", {24'd0, bits[8:1]}, {24'd0, q_exp.pop_front()});
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      n_tests = 0; n_fail = 0; n_frames = 0; n_aborts = 0;
      reset = 1'b0;
      cpu_port_out = 32'd0;
      step(3);
      chk("rst_txd", {31'd0, uart_txd}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_port_in", cpu_port_in, 32'd0);
      reset = 1'b1;
      step(3);

      // single word: latency, status and busy envelope
      cpu_port_out = 32'h4142_4344;
      expect_word(32'h4142_4344);
      step(1);
      chk("sw_txd_e1", {31'd0, uart_txd}, 32'd1);
      chk("sw_busy_e1", {31'd0, busy}, 32'd0);
      step(1);
      chk("sw_start_e2", {31'd0, uart_txd}, 32'd0);
      chk("sw_busy_e2", {31'd0, busy}, 32'd1);
      chk("sw_status_e2", cpu_port_in, 32'h0000_0009);
      step(160);
      chk("sw_txd_end", {31'd0, uart_txd}, 32'd1);
      chk("sw_busy_end", {31'd0, busy}, 32'd1);
      step(1);
      chk("sw_busy_drop", {31'd0, busy}, 32'd0);
      chk("sw_status_idle", cpu_port_in, 32'd0);
      chk("sw_queue_empty", q_exp.size(), 32'd0);
      chk("sw_frames", n_frames, 32'd4);

      // repeated value is not a write
      step(1000);
      chk("rep_frames", n_frames, 32'd4);
      chk("rep_busy", {31'd0, busy}, 32'd0);

      // back-to-back words: one idle cycle between groups
      cpu_port_out = 32'h1122_3344; expect_word(32'h1122_3344);
      step(1);
      cpu_port_out = 32'h5566_7788; expect_word(32'h5566_7788);
      step(1);
      chk("b2b_start1", {31'd0, uart_txd}, 32'd0);
      step(160);
      chk("b2b_gap", {31'd0, uart_txd}, 32'd1);
      step(1);
      chk("b2b_start2", {31'd0, uart_txd}, 32'd0);
      wait_idle(400, "b2b_idle");
      chk("b2b_queue_empty", q_exp.size(), 32'd0);

      // FIFO fill: 6 writes, 6th dropped
      cpu_port_out = 32'hA1A1_0001; expect_word(32'hA1A1_0001); step(1);
      cpu_port_out = 32'hA2A2_0002; expect_word(32'hA2A2_0002); step(1);
      cpu_port_out = 32'hA3A3_0003; expect_word(32'hA3A3_0003); step(1);
      cpu_port_out = 32'hA4A4_0004; expect_word(32'hA4A4_0004); step(1);
      cpu_port_out = 32'hA5A5_0005; expect_word(32'hA5A5_0005); step(1);
      cpu_port_out = 32'hA6A6_0006; step(1);
      chk("fill_full_status", cpu_port_in, 32'h0000_0023);
      step(1);
      chk("fill_ovf_status", cpu_port_in, 32'h0000_0027);
      wait_idle(1500, "fill_idle");
      chk("fill_queue_empty", q_exp.size(), 32'd0);
      chk("fill_sticky_ovf", cpu_port_in, 32'h0000_0004);

      cpu_port_out = 32'd0;
      reset = 1'b0;
      step(2);
      reset = 1'b1;
      step(2);
      chk("ovf_cleared", cpu_port_in, 32'd0);

      // push on the pop edge while full
      cpu_port_out = 32'hB1B1_0001; expect_word(32'hB1B1_0001); step(1);
      cpu_port_out = 32'hB2B2_0002; expect_word(32'hB2B2_0002); step(1);
      cpu_port_out = 32'hB3B3_0003; expect_word(32'hB3B3_0003); step(1);
      cpu_port_out = 32'hB4B4_0004; expect_word(32'hB4B4_0004); step(1);
      cpu_port_out = 32'hB5B5_0005; expect_word(32'hB5B5_0005); step(1);
      step(157);
      chk("pp_full_before", cpu_port_in, 32'h0000_0023);
      cpu_port_out = 32'hB6B6_0006; expect_word(32'hB6B6_0006);
      step(1);
      chk("pp_pop_start", {31'd0, uart_txd}, 32'd0);
      step(1);
      chk("pp_status_after", cpu_port_in, 32'h0000_0023);
      wait_idle(1200, "pp_idle");
      chk("pp_queue_empty", q_exp.size(), 32'd0);
      chk("pp_no_ovf", cpu_port_in, 32'd0);

      // reset during DATA
      cpu_port_out = 32'h00FF_FFFF; expect_word(32'h00FF_FFFF);
      step(12);
      chk("rm_data_low", {31'd0, uart_txd}, 32'd0);
      #3;
      reset = 1'b0;
      cpu_port_out = 32'd0;
      #1;
      chk("rm_txd_async", {31'd0, uart_txd}, 32'd1);
      chk("rm_port_in", cpu_port_in, 32'd0);
      chk("rm_busy", {31'd0, busy}, 32'd0);
      step(2);
      reset = 1'b1;
      q_exp.delete();
      frames_before = n_frames;
      step(100);
      chk("rm_no_frames", n_frames, frames_before);
      chk("rm_idle_busy", {31'd0, busy}, 32'd0);
      chk("rm_idle_txd", {31'd0, uart_txd}, 32'd1);
      chk("rm_aborted", n_aborts, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/port_uart_tx.md
Name: port_uart_tx

Overview:
- Consumer at the far end of the sc1_cpu `port_out` interface.
- Detects each new value the CPU writes to `port_out` and queues it in a small FIFO.
- Serialises each queued word as 8N1 UART bytes on `uart_txd`.
- Returns a status word to the CPU's `port_in`, so software can poll for free space and completion.

Parameters:
- WIDTH_REG, 32, width of the CPU port words; must be a multiple of 8.
- FIFO_DEPTH_LOG, 2, log2 of FIFO depth in words (default depth 4).
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_port_out  input  WIDTH_REG  driven by the CPU's `port_out`; a change of value is a write.
- cpu_port_in  output  WIDTH_REG  status word; connect to the CPU's `port_in`.
- uart_txd  output  1  serial data line; idles high.
- busy  output  1  high while the FIFO is non-empty or a word is being transmitted.

Behaviour:
- Reset (reset=0, asynchronous): all outputs and state are cleared to the values below.
  - FIFO empty; read and write pointers 0.
  - prev_port = 0.
  - FSM in IDLE.
  - uart_txd = 1, busy = 0, cpu_port_in = 0.
  - overflow flag = 0.
- Reset mid-frame aborts the frame immediately and drives uart_txd high; the partial frame is not resumed.
- Write detection:
  - Every cycle, prev_port <= cpu_port_out.
  - A push is requested when cpu_port_out != prev_port.
  - Writing the same value twice in a row is therefore not detected; software must alternate values.
  - The first value after reset is detected only if it is nonzero.
- FIFO:
  - Capacity is 2^FIFO_DEPTH_LOG words; the count field is FIFO_DEPTH_LOG+1 bits wide.
  - Push while full: the word is dropped and the sticky overflow flag is set; only reset clears it.
  - Push and pop on the same edge: both take effect and the count is unchanged. This is not an overflow, even when the FIFO is full.
  - Pointers wrap modulo the depth.
- Transmit FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If the FIFO is non-empty, pop the head into shift_word, set byte_idx=0, and go to START.
  - Popping happens on the edge after the push edge, so the minimum push-to-start-bit latency is 2 edges.
- START:
  - uart_txd=0 for CLK_DIV cycles, then go to DATA with bit_idx=0.
  - The active byte is shift_word[WIDTH_REG-1-8*byte_idx -: 8], i.e. most-significant byte first.
- DATA:
  - uart_txd = active_byte[bit_idx], LSB first.
  - Each bit is held CLK_DIV cycles; after bit 7, go to STOP.
- STOP:
  - uart_txd=1 for CLK_DIV cycles.
  - If byte_idx < WIDTH_REG/8-1: increment byte_idx and go to START (back-to-back bytes, no extra idle).
  - Otherwise go to IDLE. When the FIFO is non-empty, the next word's start bit follows after exactly one IDLE cycle.
- Baud counter: counts 0..CLK_DIV-1 and resets on every state entry. Each frame is exactly 10*CLK_DIV cycles.
- uart_txd is registered and glitch-free.
- busy is registered: 1 when the FSM is not in IDLE or the FIFO count is nonzero.
- cpu_port_in is registered, updated every cycle:
  - bit0 busy.
  - bit1 FIFO full.
  - bit2 overflow.
  - bits [3 +: FIFO_DEPTH_LOG+1] FIFO count.
  - all remaining bits 0.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert reset=0 during the DATA state of a frame.
  - Response: uart_txd=1 within the same cycle (async); cpu_port_in=0; after release nothing is sent until cpu_port_out changes.
- Single word (CLK_DIV=4, WIDTH_REG=32):
  - Stimulus: cpu_port_out 0 -> 0x41424344.
  - Response: bytes 0x41, 0x42, 0x43, 0x44 on uart_txd, each start=0, LSB first, stop=1. Total 160 cycles of activity.
  - Start bit begins 2 edges after the change is sampled.
  - busy=1 throughout and returns to 0 one cycle after the final stop bit.
- Repeated value:
  - Stimulus: hold cpu_port_out at 0x41424344 for 1000 cycles after the first word.
  - Response: exactly one frame group (4 bytes) is sent.
- FIFO fill (depth 4):
  - Stimulus: write 6 distinct values on consecutive cycles while idle.
  - Response:
    - The first word pops immediately and 4 more are queued.
    - The 6th arrives while full and is dropped, so overflow bit2=1.
    - Exactly 5 words are transmitted, in write order.
    - While full, cpu_port_in[1]=1 and count=4.
- Simultaneous push and pop:
  - Stimulus: with the FIFO full, push on the exact edge the FSM pops.
  - Response: count stays 4, overflow stays 0, and the new word is transmitted last.
- Back-to-back words:
  - Stimulus: queue 2 words before the first finishes.
  - Response: the second word's start bit begins exactly 1 cycle after the first word's last stop bit ends.
